i2s_sample_fifo: RTL and testbench
==================================

// Module: i2s_sample_fifo
// PURPOSE
//   Sample buffer directly upstream of the i2s transmitter.
//   The j1a CPU I/O writes 16-bit PCM samples at bursty rate; the block drives the transmitter's parallel value input.
//   One sample is popped per channel slot, i.e. per lrclk edge (rising or falling) sampled from the transmitter.
//   Underrun outputs silence and sets sticky flags, so software pacing bugs are visible, not audible garbage.
// PARAMETERS
//   WIDTH       16  sample width; matches the i2s value input
//   DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 (16 samples = 8 stereo frames)
//   LOW_WATER   4   level at/below which irq asserts (used only with I2S_FIFO_LOWWATER_EN)
// PORTS
//   clk        in   1             system clock; same clock as the i2s transmitter
//   reset      in   1             asynchronous, active-high reset
//   wr_data    in   WIDTH         sample from CPU I/O write
//   wr_en      in   1             push strobe, one sample per cycle high
//   clr_flags  in   1             clears underrun/overflow sticky bits
//   lrclk      in   1             word-select fed back from the i2s transmitter
//   value      out  WIDTH         current sample to the i2s transmitter
//   level      out  DEPTH_LOG2+1  samples stored (0..2**DEPTH_LOG2)
//   full       out  1             level == 2**DEPTH_LOG2
//   empty      out  1             level == 0
//   underrun   out  1             sticky: slot edge seen while empty
//   overflow   out  1             sticky: wr_en while full
//   irq        out  1             low-water request (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, immediate):
//     - value=0, level=0, empty=1, full=0, underrun=0, overflow=0, irq=0
//     - read/write pointers cleared; lrclk_q=0 (transmitter also resets lrclk low, so no spurious edge)
//   Slot edge:
//     - lrclk_q <= lrclk each clk; slot = lrclk ^ lrclk_q (one-cycle pulse per toggle)
//     - slot && !empty: value <= mem[rd_ptr], rd_ptr++ -> value updates 2 clk after the lrclk toggle
//     - slot && empty: value <= 0, underrun <= 1; pointers unchanged
//     - value holds between slot edges; the transmitter samples it >=3 clk after its lrclk toggle (sclk >= clk/4)
//   Push:
//     - wr_en && !full: mem[wr_ptr] <= wr_data, wr_ptr++
//     - wr_en && full: data dropped, overflow <= 1
//   Pointers: DEPTH_LOG2+1 bits, natural wrap; level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1)
//   Simultaneous push and pop:
//     - level unchanged; both pointers advance
//     - at full: pop frees the slot and the push is accepted (full evaluated as pop-aware)
//     - at empty: no bypass; slot underruns and the pushed word is stored
//   clr_flags concurrent with a new underrun/overflow event: set wins
//   Reset mid-frame: FIFO contents discarded; the next sample comes only after new pushes
//   Ordering: mono or left/right interleaving is the writer's job; the FIFO is strictly in-order
// CONFIGURATION
//   I2S_FIFO_LOWWATER_EN defined:
//     - irq registered, = (level <= LOW_WATER) && !reset
//     - irq level-sensitive; deasserts the cycle after level exceeds LOW_WATER
//   I2S_FIFO_LOWWATER_EN undefined: irq tied 0, LOW_WATER ignored; port list unchanged
// STRUCTURE
//   Package i2s_fifo_pkg:
//     - WIDTH and DEPTH_LOG2 defaults
//     - sample_t (WIDTH), ptr_t (DEPTH_LOG2+1), level_t
//   Sub-module i2s_fifo_mem:
//     - 2**DEPTH_LOG2 x WIDTH array, synchronous write, asynchronous read
//     - top keeps pointers, flags, slot detect and the value register
// TESTING
//   - Reset, push 0x1111,0x2222,0x3333; toggle lrclk 3x -> value 0x1111,0x2222,0x3333, each 2 clk after its toggle; level 3->0
//   - Empty FIFO, toggle lrclk -> value=0x0000, underrun=1; pulse clr_flags -> underrun=0
//   - Push 17 words (DEPTH_LOG2=4) -> full=1 after 16th, overflow=1, level=16; 17th word never appears on value
//   - Full FIFO, wr_en=1 on slot cycle -> push accepted, level stays 16, overflow stays 0
//   - 40 push/pop cycles -> pointer wrap; output order preserved across wrap, level never off by one
//   - Reset asserted mid-stream (level=5) -> value=0, level=0 immediately; with I2S_FIFO_LOWWATER_EN, irq=1 for level<=4 and 0 at level 5

Source files
------------

// File: rtl/i2s_fifo_pkg.sv
// Shared defaults and types for the i2s sample FIFO slice.
package i2s_fifo_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_DEPTH_LOG2 = 4;
    localparam int DEF_LOW_WATER  = 4;

    typedef logic [DEF_WIDTH-1:0]    sample_t;
    typedef logic [DEF_DEPTH_LOG2:0] ptr_t;
    typedef logic [DEF_DEPTH_LOG2:0] level_t;

endpackage

// File: rtl/i2s_sample_fifo_if.sv
// Bus between the CPU/transmitter side (master) and the sample FIFO (slave).
interface i2s_sample_fifo_if
    import i2s_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) ();

    logic [WIDTH-1:0]    wr_data;
    logic                wr_en;
    logic                clr_flags;
    logic                lrclk;
    logic [WIDTH-1:0]    value;
    logic [DEPTH_LOG2:0] level;
    logic                full;
    logic                empty;
    logic                underrun;
    logic                overflow;
    logic                irq;

    modport master (
        output wr_data, wr_en, clr_flags, lrclk,
        input  value, level, full, empty, underrun, overflow, irq
    );

    modport slave (
        input  wr_data, wr_en, clr_flags, lrclk,
        output value, level, full, empty, underrun, overflow, irq
    );

endinterface

// File: rtl/i2s_fifo_mem.sv
// Sample storage: synchronous write, asynchronous read.
module i2s_fifo_mem
    import i2s_fifo_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_DEPTH_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset; the pointers decide which words are valid,
    // so resetting storage would only cost flops and block RAM inference.
    // NOTE: sequential state is always written with <= so every reader sees
    // the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2s_sample_fifo.sv
// Sample FIFO feeding the i2s transmitter; pops one sample per lrclk edge.
// Optional low-water irq enabled by defining I2S_FIFO_LOWWATER_EN.
module i2s_sample_fifo
    import i2s_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LOW_WATER  = DEF_LOW_WATER
) (
    input  logic             clk,
    input  logic             reset,
    i2s_sample_fifo_if.slave bus
);

`ifdef I2S_FIFO_LOWWATER_EN
    localparam bit LOWWATER_EN = 1'b1;
`else
    localparam bit LOWWATER_EN = 1'b0;
`endif

    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] LOW_LEVEL  = LOW_WATER[DEPTH_LOG2:0];

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] level;
    logic [WIDTH-1:0]    rd_data;
    logic [WIDTH-1:0]    value_q;
    logic                lrclk_q;
    logic                slot_q;
    logic                underrun_q;
    logic                overflow_q;
    logic                irq_q;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push;
    logic                underrun_evt;
    logic                overflow_evt;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == FULL_LEVEL);
    assign empty = (level == '0);

    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign pop          = slot_q && !empty;
    assign push         = bus.wr_en && (!full || pop);
    assign underrun_evt = slot_q && empty;
    assign overflow_evt = bus.wr_en && full && !pop;

    i2s_fifo_mem #(
        .WIDTH (WIDTH),
        .ADDR_W(DEPTH_LOG2)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr[DEPTH_LOG2-1:0]),
        .wdata(bus.wr_data),
        .raddr(rd_ptr[DEPTH_LOG2-1:0]),
        .rdata(rd_data)
    );

    // The slot pulse is registered, so value lands two clocks after the toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lrclk_q    <= 1'b0;
            slot_q     <= 1'b0;
            value_q    <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            lrclk_q <= bus.lrclk;
            slot_q  <= bus.lrclk ^ lrclk_q;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                value_q <= rd_data;
            end else if (underrun_evt) begin
                value_q <= '0;
            end

            if (underrun_evt) begin
                underrun_q <= 1'b1;
            end else if (bus.clr_flags) begin
                underrun_q <= 1'b0;
            end

            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_flags) begin
                overflow_q <= 1'b0;
            end

            irq_q <= LOWWATER_EN && (level <= LOW_LEVEL);
        end
    end

    assign bus.value    = value_q;
    assign bus.level    = level;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.underrun = underrun_q;
    assign bus.overflow = overflow_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Scoreboard bench for i2s_sample_fifo: stimulus queues expected samples,
// a monitor compares value two clocks after every lrclk toggle.
module tb_i2s_sample_fifo;
    import i2s_fifo_pkg::*;

`ifdef I2S_FIFO_LOWWATER_EN
    localparam bit LW_EN = 1'b1;
`else
    localparam bit LW_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    sample_t exp_q[$];

    always #5 clk = ~clk;

    i2s_sample_fifo_if bus ();

    i2s_sample_fifo dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input sample_t d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic slot_pop(input sample_t e);
        exp_q.push_back(e);
        bus.lrclk = ~bus.lrclk;
        repeat (4) step();
    endtask

    // Toggle lrclk and push d in the very cycle the resulting pop happens.
    task automatic slot_pop_with_push(input sample_t e, input sample_t d);
        exp_q.push_back(e);
        bus.lrclk = ~bus.lrclk;
        step();
        push(d);
    endtask

    task automatic pulse_clr();
        bus.clr_flags = 1'b1;
        step();
        bus.clr_flags = 1'b0;
    endtask

    initial begin : monitor
        logic    lr_seen;
        int      cd;
        sample_t held;
        sample_t e;
        lr_seen = 1'b0;
        cd      = 0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                lr_seen = bus.lrclk;
                cd      = 0;
            end else begin
                if (cd == 2) begin
                    check("value_hold_1clk", bus.value, held);
                    cd = 1;
                end else if (cd == 1) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_pop", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("value", bus.value, e);
                    end
                    cd = 0;
                end
                if (bus.lrclk !== lr_seen) begin
                    lr_seen = bus.lrclk;
                    held    = bus.value;
                    cd      = 2;
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_data   = '0;
        bus.clr_flags = 1'b0;
        bus.lrclk     = 1'b0;
        repeat (2) step();

        check("rst_value",    bus.value,    0);
        check("rst_level",    bus.level,    0);
        check("rst_empty",    bus.empty,    1);
        check("rst_full",     bus.full,     0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_irq",      bus.irq,      0);

        reset = 1'b0;
        repeat (2) step();
        check("irq_idle_empty", bus.irq, LW_EN);

        // In-order delivery of three samples
        push(16'h1111);
        push(16'h2222);
        push(16'h3333);
        check("t1_level3", bus.level, 3);
        check("t1_not_empty", bus.empty, 0);
        slot_pop(16'h1111);
        slot_pop(16'h2222);
        slot_pop(16'h3333);
        check("t1_level0", bus.level, 0);
        check("t1_empty", bus.empty, 1);
        check("t1_no_underrun", bus.underrun, 0);

        // Underrun outputs silence; clear; set wins over a concurrent clear
        slot_pop(16'h0000);
        check("t2_underrun_set", bus.underrun, 1);
        check("t2_overflow_clear", bus.overflow, 0);
        pulse_clr();
        check("t2_underrun_cleared", bus.underrun, 0);
        exp_q.push_back(16'h0000);
        bus.lrclk = ~bus.lrclk;
        step();
        pulse_clr();
        repeat (2) step();
        check("t2_set_wins", bus.underrun, 1);
        pulse_clr();
        check("t2_underrun_cleared2", bus.underrun, 0);

        // Fill past full
        for (int i = 0; i < 17; i++) begin
            push(sample_t'(16'hA000 + i));
            if (i == 15) begin
                check("t3_full_at16", bus.full, 1);
                check("t3_level16", bus.level, 16);
                check("t3_no_overflow_yet", bus.overflow, 0);
            end
        end
        check("t3_overflow", bus.overflow, 1);
        check("t3_level_after17", bus.level, 16);
        step();
        check("t3_irq_full", bus.irq, 0);
        pulse_clr();
        check("t3_overflow_cleared", bus.overflow, 0);

        // Push accepted at full when it coincides with a pop
        slot_pop_with_push(16'hA000, 16'hBEEF);
        check("t4_level_stays16", bus.level, 16);
        check("t4_full", bus.full, 1);
        check("t4_no_overflow", bus.overflow, 0);
        repeat (2) step();
        for (int i = 1; i < 16; i++) begin
            slot_pop(sample_t'(16'hA000 + i));
        end
        slot_pop(16'hBEEF);
        check("t4_drained_level", bus.level, 0);
        check("t4_no_underrun", bus.underrun, 0);

        // Steady push/pop across pointer wrap
        push(16'hC000);
        push(16'hC001);
        for (int j = 0; j < 40; j++) begin
            slot_pop_with_push(sample_t'(16'hC000 + j), sample_t'(16'hC002 + j));
            check("t5_level_steady", bus.level, 2);
            repeat (2) step();
        end
        slot_pop(16'hC028);
        slot_pop(16'hC029);
        check("t5_level0", bus.level, 0);
        check("t5_no_underrun", bus.underrun, 0);

        // Low-water boundary, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            push(sample_t'(16'hD000 + i));
        end
        repeat (2) step();
        check("t6_level4", bus.level, 4);
        check("t6_irq_at4", bus.irq, LW_EN);
        push(16'hD004);
        repeat (2) step();
        check("t6_level5", bus.level, 5);
        check("t6_irq_at5", bus.irq, 0);
        #2;
        reset     = 1'b1;
        bus.lrclk = 1'b0;
        #1;
        check("t6_rst_value", bus.value, 0);
        check("t6_rst_level", bus.level, 0);
        check("t6_rst_empty", bus.empty, 1);
        check("t6_rst_irq", bus.irq, 0);
        step();
        reset = 1'b0;
        repeat (2) step();
        slot_pop(16'h0000);
        check("t6_discarded_underrun", bus.underrun, 1);
        check("t6_level_after", bus.level, 0);

        repeat (4) step();
        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
